mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the processor's single-ported data RAM between the instruction-fetch refill path (read-only) and the load/store unit (read/write) inside RISCV32IProc. Accepts one transaction at a time, drives the RAM port, waits a fixed RAM latency, and returns completion and read data to the owning requester. Load/store has priority; a starvation counter guarantees fetch progress.

## Interface
- dataW, 32, data word width (bits)
- RAMAddrSize, 32, byte address width
- RAMLatency, 1, cycles from ram_req to valid ram_rdata (1..7)
- StarveLimit, 4, consecutive LS grants allowed while IF waits (1..15)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  RAMAddrSize  fetch byte address
- if_gnt  out  1  one-cycle accept pulse
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  dataW  fetch data, valid with if_done
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  RAMAddrSize  byte address
- ls_wdata  in  dataW  store data
- ls_be  in  dataW/8  byte enables (stores only)
- ls_gnt  out  1  one-cycle accept pulse
- ls_done  out  1  one-cycle completion pulse (loads and stores)
- ls_rdata  out  dataW  load data, valid with ls_done
- ram_req  out  1  one-cycle RAM access strobe
- ram_we  out  1  write strobe
- ram_addr  out  RAMAddrSize-2  word address = byte address [RAMAddrSize-1:2]
- ram_wdata  out  dataW  write data
- ram_be  out  dataW/8  byte enables; all-ones for reads
- ram_rdata  in  dataW  read data, valid RAMLatency cycles after ram_req

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any request pending, grant one: gnt pulse, ram_req pulse, RAM outputs driven from the winner's inputs in the same cycle (combinational from inputs, registered owner); go WAIT, load latency counter with RAMLatency-1. No request: stay IDLE.
- WAIT: decrement counter; at 0 register ram_rdata into the owner's rdata register; go RESP.
- RESP: owner's done pulses high for one cycle; return to IDLE.
- Arbitration: LS wins unless starve count == StarveLimit with if_req high, then IF wins. Starve count increments on each LS grant while if_req high, clears on IF grant or when if_req low; saturates at StarveLimit.
- Low two address bits dropped; alignment is the requester's responsibility.
- if_rdata/ls_rdata hold last value until next completion for that port.
- Request deasserted before gnt: withdrawn, no effect.

## Timing
- Reset: state IDLE, starve count 0; if_gnt, ls_gnt, if_done, ls_done, ram_req, ram_we 0; ram_addr, ram_wdata, if_rdata, ls_rdata 0; ram_be 0.
- Grant in cycle t: ram_req at t, ram_rdata sampled at t+RAMLatency, done at t+RAMLatency+1, next grant earliest t+RAMLatency+2.
- Throughput: one transaction per RAMLatency+2 cycles.
- Simultaneous if_req and ls_req in IDLE: arbitration rule above; loser's request stays pending.
- Requests arriving in WAIT/RESP wait; no grants outside IDLE.
- Reset mid-transaction: aborts; no done pulse, no further RAM access.
- ram_we/ram_be/ram_wdata meaningful only when ram_req high; driven 0 otherwise.

## Structure
- Shared package riscv_mem_pkg: state enum (IDLE, WAIT, RESP), owner enum (OWN_IF, OWN_LS), word-address slicing constant (byte-offset width 2).
- No sub-module required; starvation counter and latency counter stay inline.

## Test plan
- IF read only: if_addr 0x0000_0010, RAM word 4 = 0x0051_0513 -> ram_req t, ram_addr 4, if_done t+2 with if_rdata 0x0051_0513 (RAMLatency=1).
- LS store: addr 0x20, wdata 0xDEAD_BEEF, be 4'b0011 -> ram_we 1, ram_addr 8, ram_be 0011, ls_done at t+2; later load of 0x20 returns 0x0000_BEEF when preloaded 0.
- Simultaneous if_req/ls_req in IDLE -> ls_gnt first, if_gnt at t+3.
- Starvation: ls_req held high continuously with if_req high, StarveLimit=4 -> four LS grants, then IF grant, then LS resumes.
- RAMLatency=3 -> done exactly 4 cycles after gnt; no grant during those cycles.
- Reset asserted in WAIT -> next cycle all outputs 0, no done pulse; new request after reset granted normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states, transaction owner,
// and the byte-offset width stripped off byte addresses to form word addresses.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam int unsigned ByteOffW = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported data RAM between the fetch refill path and the
// load/store unit, one transaction at a time, with load/store priority.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned dataW       = 32,
  parameter int unsigned RAMAddrSize = 32,
  parameter int unsigned RAMLatency  = 1,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      if_req,
  input  logic [RAMAddrSize-1:0]    if_addr,
  output logic                      if_gnt,
  output logic                      if_done,
  output logic [dataW-1:0]          if_rdata,
  input  logic                      ls_req,
  input  logic                      ls_we,
  input  logic [RAMAddrSize-1:0]    ls_addr,
  input  logic [dataW-1:0]          ls_wdata,
  input  logic [dataW/8-1:0]        ls_be,
  output logic                      ls_gnt,
  output logic                      ls_done,
  output logic [dataW-1:0]          ls_rdata,
  output logic                      ram_req,
  output logic                      ram_we,
  output logic [RAMAddrSize-3:0]    ram_addr,
  output logic [dataW-1:0]          ram_wdata,
  output logic [dataW/8-1:0]        ram_be,
  input  logic [dataW-1:0]          ram_rdata
);

  localparam int unsigned BeW       = dataW / 8;
  localparam logic [2:0]  LatLoad   = 3'(RAMLatency - 1);
  localparam logic [3:0]  StarveMax = 4'(StarveLimit);

  arb_state_e       state_q;
  arb_owner_e       owner_q;
  logic [2:0]       lat_cnt_q;
  logic [3:0]       starve_q;
  logic [3:0]       starve_d;
  logic             if_done_q;
  logic             ls_done_q;
  logic [dataW-1:0] if_rdata_q;
  logic [dataW-1:0] ls_rdata_q;
  logic             if_win_s;
  logic             ls_win_s;
  logic             ls_store_s;
  logic             addr_lsb_unused;

  // Requesters guarantee alignment, so the byte-offset bits carry no information.
  assign addr_lsb_unused = ^{if_addr[ByteOffW-1:0], ls_addr[ByteOffW-1:0]};

  // Pick the winner in IDLE: LS by default, IF once its starvation budget is spent.
  always_comb begin
    if_win_s = 1'b0;
    ls_win_s = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (if_req && (!ls_req || starve_q == StarveMax)) begin
        if_win_s = 1'b1;
      end else begin
        ls_win_s = ls_req;
      end
    end else begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end
  end

  // Count LS grants that bypass a waiting fetch; any fetch grant or idle fetch clears it.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_win_s) begin
      starve_d = 4'd0;
    end else if (ls_win_s && starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  assign ls_store_s = ls_win_s & ls_we;

  // Drive the RAM port straight from the winner's inputs in the grant cycle.
  always_comb begin
    ram_req   = if_win_s | ls_win_s;
    ram_we    = ls_store_s;
    ram_addr  = {(RAMAddrSize-ByteOffW){1'b0}};
    ram_wdata = {dataW{1'b0}};
    ram_be    = {BeW{1'b0}};
    if (if_win_s) begin
      ram_addr = if_addr[RAMAddrSize-1:ByteOffW];
      ram_be   = {BeW{1'b1}};
    end else if (ls_win_s) begin
      ram_addr  = ls_addr[RAMAddrSize-1:ByteOffW];
      ram_wdata = ls_store_s ? ls_wdata : {dataW{1'b0}};
      ram_be    = ls_store_s ? ls_be : {BeW{1'b1}};
    end else begin
      ram_addr  = {(RAMAddrSize-ByteOffW){1'b0}};
      ram_wdata = {dataW{1'b0}};
      ram_be    = {BeW{1'b0}};
    end
  end

  // Transaction FSM: grant, wait out the RAM latency, then pulse the owner's done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      lat_cnt_q  <= 3'd0;
      starve_q   <= 4'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_rdata_q <= {dataW{1'b0}};
      ls_rdata_q <= {dataW{1'b0}};
    end else begin
      starve_q  <= starve_d;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_win_s || ls_win_s) begin
            owner_q   <= if_win_s ? OWN_IF : OWN_LS;
            lat_cnt_q <= LatLoad;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_q == 3'd0) begin
            if (owner_q == OWN_IF) begin
              if_rdata_q <= ram_rdata;
              if_done_q  <= 1'b1;
            end else begin
              ls_rdata_q <= ram_rdata;
              ls_done_q  <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt   = if_win_s;
  assign ls_gnt   = ls_win_s;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model checks instance A
// (RAMLatency 1) every cycle; instance B (RAMLatency 3) gets hand-computed checks.
module tb_mem_port_arbiter;

  localparam int LAT = 1;
  localparam int LIM = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        if_req, if_gnt, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_done;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        ram_req, ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_be;

  logic        b_if_req, b_if_gnt, b_if_done;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_ls_req, b_ls_we, b_ls_gnt, b_ls_done;
  logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic [3:0]  b_ls_be;
  logic        b_ram_req, b_ram_we;
  logic [29:0] b_ram_addr;
  logic [31:0] b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_port_arbiter #(.dataW(32), .RAMAddrSize(32), .RAMLatency(LAT), .StarveLimit(LIM)) dut_a (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.dataW(32), .RAMAddrSize(32), .RAMLatency(3), .StarveLimit(LIM)) dut_b (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata), .ls_be(b_ls_be),
    .ls_gnt(b_ls_gnt), .ls_done(b_ls_done), .ls_rdata(b_ls_rdata),
    .ram_req(b_ram_req), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_be(b_ram_be), .ram_rdata(b_ram_rdata)
  );

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // RAM A: read-before-write, data present only in the cycle RAMLatency after ram_req.
  logic [31:0] mem [0:63];
  always @(posedge clock) begin
    ram_rdata <= ram_req ? mem[ram_addr[5:0]] : 32'h0;
    if (ram_req && ram_we) mem[ram_addr[5:0]] <= merge(mem[ram_addr[5:0]], ram_wdata, ram_be);
  end

  // RAM B: three-stage pipe returning a word derived from the address.
  logic [31:0] b_p1, b_p2;
  always @(posedge clock) begin
    b_p1        <= b_ram_req ? ({2'b00, b_ram_addr} ^ 32'hC0DE_0000) : 32'h0;
    b_p2        <= b_p1;
    b_ram_rdata <= b_p2;
  end

  // Transaction-level model of instance A.
  logic [31:0] ref_mem [0:63];
  int          free_at = 0;
  int          done_at = -1;
  bit          own_ls = 1'b0;
  int          starve = 0;
  logic [31:0] pend = 32'h0, m_if_rd = 32'h0, m_ls_rd = 32'h0;
  bit          gi, gl, wr;
  logic [29:0] ea;
  logic [31:0] ew;
  logic [3:0]  eb;

  always @(negedge clock) begin
    gi = !reset && cyc >= free_at && if_req && (!ls_req || starve == LIM);
    gl = !reset && cyc >= free_at && !gi && ls_req;
    wr = gl && ls_we;
    ea = gi ? 30'(if_addr >> 2) : gl ? 30'(ls_addr >> 2) : 30'h0;
    ew = wr ? ls_wdata : 32'h0;
    eb = wr ? ls_be : (gi || gl) ? 4'hF : 4'h0;
    if (cyc == done_at) begin
      if (own_ls) m_ls_rd = pend;
      else        m_if_rd = pend;
    end
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, gi});
    chk("ls_gnt", {31'd0, ls_gnt}, {31'd0, gl});
    chk("ram_req", {31'd0, ram_req}, {31'd0, gi | gl});
    chk("ram_we", {31'd0, ram_we}, {31'd0, wr});
    chk("ram_addr", {2'b00, ram_addr}, {2'b00, ea});
    chk("ram_wdata", ram_wdata, ew);
    chk("ram_be", {28'd0, ram_be}, {28'd0, eb});
    chk("if_done", {31'd0, if_done}, {31'd0, (cyc == done_at) && !own_ls});
    chk("ls_done", {31'd0, ls_done}, {31'd0, (cyc == done_at) && own_ls});
    chk("if_rdata", if_rdata, m_if_rd);
    chk("ls_rdata", ls_rdata, m_ls_rd);
    if (reset) begin
      free_at = cyc + 1;
      done_at = -1;
      starve  = 0;
      m_if_rd = 32'h0;
      m_ls_rd = 32'h0;
    end else begin
      if (gi || gl) begin
        free_at = cyc + LAT + 2;
        done_at = cyc + LAT + 1;
        own_ls  = gl;
        pend    = ref_mem[ea[5:0]];
        if (wr) ref_mem[ea[5:0]] = merge(ref_mem[ea[5:0]], ls_wdata, ls_be);
      end
      if (!if_req || gi)            starve = 0;
      else if (gl && starve < LIM)  starve = starve + 1;
    end
  end

  task automatic req_one(input bit is_ls, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int tg, output logic [29:0] g_addr,
                         output logic g_we, output logic [3:0] g_be);
    tg = -1;
    g_addr = 30'h0; g_we = 1'b0; g_be = 4'h0;
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd; ls_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 0; k < 40 && tg < 0; k++) begin
      @(negedge clock);
      if (is_ls ? ls_gnt : if_gnt) begin
        tg = cyc; g_addr = ram_addr; g_we = ram_we; g_be = ram_be;
      end
    end
    if (tg < 0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no grant within 40 cycles (is_ls=%0d)", is_ls);
    end
    @(posedge clock); #1;
    ls_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic run_both(input int n_ls, input string exp_ord);
    int nl = 0;
    bit idone = 1'b0;
    int last = -1;
    string ord = "";
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
    for (int k = 0; k < 100 && !(nl == n_ls && idone); k++) begin
      @(negedge clock);
      if (ls_gnt || if_gnt) begin
        if (last >= 0) chk("grant_spacing", cyc - last, LAT + 2);
        last = cyc;
      end
      if (ls_gnt) begin ord = {ord, "L"}; nl++; end
      if (if_gnt) begin ord = {ord, "I"}; idone = 1'b1; end
      @(posedge clock); #1;
      if (nl == n_ls) ls_req = 1'b0;
      if (idone)      if_req = 1'b0;
    end
    ls_req = 1'b0; if_req = 1'b0;
    checks++;
    if (ord != exp_ord) begin
      errors++;
      $display("FAIL grant_order: got %s expected %s", ord, exp_ord);
    end
  endtask

  int          tg, tb, cnt;
  logic [29:0] ga;
  logic        gw;
  logic [3:0]  gb;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = {16'hA5A5, 16'(i)};
      ref_mem[i] = {16'hA5A5, 16'(i)};
    end
    mem[4] = 32'h0051_0513; ref_mem[4] = 32'h0051_0513;
    mem[8] = 32'h0;         ref_mem[8] = 32'h0;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_be = 4'h0;
    b_if_req = 1'b0; b_if_addr = 32'h0;
    b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_addr = 32'h0; b_ls_wdata = 32'h0; b_ls_be = 4'h0;
    @(negedge clock);
    chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Fetch read of word 4.
    req_one(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, tg, ga, gw, gb);
    chk("t1_ram_addr", {2'b00, ga}, 32'd4);
    @(negedge clock); @(negedge clock);
    chk("t1_if_done", {31'd0, if_done}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h0051_0513);
    @(posedge clock); #1;

    // Partial store then load back.
    req_one(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011, tg, ga, gw, gb);
    chk("t2_ram_we", {31'd0, gw}, 32'd1);
    chk("t2_ram_addr", {2'b00, ga}, 32'd8);
    chk("t2_ram_be", {28'd0, gb}, 32'h3);
    @(negedge clock); @(negedge clock);
    chk("t2_ls_done", {31'd0, ls_done}, 32'd1);
    @(posedge clock); #1;
    req_one(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, tg, ga, gw, gb);
    @(negedge clock); @(negedge clock);
    chk("t2_load_data", ls_rdata, 32'h0000_BEEF);
    @(posedge clock); #1;

    run_both(1, "LI");
    repeat (3) @(posedge clock); #1;
    run_both(6, "LLLLILL");
    repeat (3) @(posedge clock); #1;

    // A fetch request raised and dropped while busy must leave no trace.
    req_one(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, tg, ga, gw, gb);
    if_req = 1'b1; if_addr = 32'h18;
    @(posedge clock); #1;
    if_req = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clock); if (if_gnt) cnt++; end
    chk("withdraw_no_gnt", cnt, 32'd0);
    @(posedge clock); #1;

    // Reset while waiting on the RAM aborts the transaction.
    req_one(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, tg, ga, gw, gb);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_if_rdata", if_rdata, 32'h0);
    chk("rst_mid_ram_req", {31'd0, ram_req}, 32'd0);
    cnt = 0;
    repeat (4) begin if (if_done) cnt++; @(negedge clock); end
    chk("rst_mid_no_done", cnt, 32'd0);
    @(posedge clock); #1;
    req_one(1'b0, 1'b0, 32'h24, 32'h0, 4'h0, tg, ga, gw, gb);
    @(negedge clock); @(negedge clock);
    chk("post_rst_done", {31'd0, if_done}, 32'd1);
    chk("post_rst_rdata", if_rdata, 32'hA5A5_0009);
    @(posedge clock); #1;

    // Instance B, RAMLatency 3: LS wins, done 4 cycles later, IF granted 5 cycles later.
    b_ls_req = 1'b1; b_ls_addr = 32'h8; b_if_req = 1'b1; b_if_addr = 32'h30;
    tb = -1;
    for (int k = 0; k < 20 && tb < 0; k++) begin
      @(negedge clock);
      if (b_ls_gnt) begin
        tb = cyc;
        chk("b_if_gnt_lose", {31'd0, b_if_gnt}, 32'd0);
        chk("b_ram_addr", {2'b00, b_ram_addr}, 32'd2);
        chk("b_ram_be", {28'd0, b_ram_be}, 32'hF);
        chk("b_ram_we", {31'd0, b_ram_we}, 32'd0);
        chk("b_ram_wdata", b_ram_wdata, 32'h0);
      end
    end
    if (tb < 0) begin
      checks++; errors++;
      $display("FAIL b_grant_timeout: no LS grant within 20 cycles");
    end
    @(posedge clock); #1;
    b_ls_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("b_busy_if_gnt", {31'd0, b_if_gnt}, 32'd0);
      chk("b_busy_ram_req", {31'd0, b_ram_req}, 32'd0);
      chk("b_ls_done", {31'd0, b_ls_done}, {31'd0, k == 4});
    end
    chk("b_ls_rdata", b_ls_rdata, 32'hC0DE_0002);
    @(negedge clock);
    chk("b_if_gnt_t5", {31'd0, b_if_gnt}, 32'd1);
    @(posedge clock); #1;
    b_if_req = 1'b0;
    repeat (4) @(negedge clock);
    chk("b_if_done", {31'd0, b_if_done}, 32'd1);
    chk("b_if_rdata", b_if_rdata, 32'hC0DE_000C);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
